// File: rtl/conv_pkg.sv
// Constants and loader state encoding shared by the CONV engine and its image loader.
package conv_pkg;

    localparam int DATA_W     = 20;
    localparam int ADDR_W     = 12;
    localparam int IMG_PIXELS = 4096;
    localparam int CYC_W      = 24;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        HANDOFF = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/conv_img_ram.sv
// Single image buffer: one synchronous write port and one zero-latency read port.
module conv_img_ram
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [IMG_PIXELS];

    // NOTE: the array has no reset on purpose; contents are only valid once a frame is written,
    // and a reset branch would prevent mapping to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read samples the array before the clock edge, so a same-cycle write shows old data.
    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_img_loader.sv
// Loads one frame from a valid/ready stream, hands the buffer to CONV and tracks its run.
module conv_img_loader
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              ready,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CYC_W-1:0]  run_cycles
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic              armed;
    logic              accept;
    logic              last_beat;

    // armed holds s_ready low for exactly one cycle after reset is released.
    assign s_ready   = (state == LOAD) && armed;
    assign ready     = (state == LOAD);
    assign accept    = s_valid && s_ready;
    assign last_beat = (wr_ptr == LAST_ADDR);

    // NOTE: every combinational output gets its default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && last_beat) state_next = HANDOFF;
            HANDOFF: if (busy)                state_next = RUN;
            RUN:     if (!busy)               state_next = DONE;
            DONE:                             state_next = DONE;
            default:                          state_next = LOAD;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // An early s_last throws away the partial frame; a missing one still completes the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (last_beat || s_last) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (s_last != last_beat) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cycles <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == RUN) && !busy;
            if ((state == RUN) && (run_cycles != '1)) begin
                run_cycles <= run_cycles + 1'b1;
            end
        end
    end

    conv_img_ram u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (iaddr),
        .rdata (idata)
    );

endmodule
